// File: rtl/brl_sequencer_pkg.sv
// brl_sequencer_pkg: phase codes and default duty width shared by the sequencer and its bus
package brl_sequencer_pkg;
  localparam int DUTY_W = 10;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } phase_e;
endpackage

// File: rtl/brl_sequencer_if.sv
// brl_sequencer_if: control inputs and duty/status outputs between the enable logic, PWM and sequencer
interface brl_sequencer_if
  import brl_sequencer_pkg::*;
#(
  parameter int pWIDTH = DUTY_W
);
  logic              en;
  logic              oneshot;
  logic              end_tick;
  logic [pWIDTH-1:0] cyc_duty;
  logic [2:0]        phase;
  logic              cyc_done;
  modport master (output en, oneshot, end_tick, input cyc_duty, phase, cyc_done);
  modport slave  (input en, oneshot, end_tick, output cyc_duty, phase, cyc_done);
endinterface

// File: rtl/brl_tick_div.sv
// brl_tick_div: passes every pDIV-th input tick; output is combinational from tick_in and the count
module brl_tick_div #(
  parameter int pDIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick_in,
  output logic tick_out
);
  localparam int CW = pDIV > 1 ? $clog2(pDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(pDIV - 1);
  logic [CW-1:0] cnt_q;
  assign tick_out = tick_in && cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (tick_in) cnt_q <= tick_out ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/brl_sequencer.sv
// brl_sequencer: breathing-light envelope (rise, hold high, fall, hold low) updating the PWM duty once per step
module brl_sequencer
  import brl_sequencer_pkg::*;
#(
  parameter int pWIDTH   = DUTY_W,
  parameter int pMAX     = 200,
  parameter int pSTEP    = 5,
  parameter int pDIV     = 1,
  parameter int pHOLD_HI = 10,
  parameter int pHOLD_LO = 10
) (
  input logic            clk,
  input logic            rst_n,
  brl_sequencer_if.slave bus
);
  localparam int HMAX = pHOLD_HI > pHOLD_LO ? pHOLD_HI : pHOLD_LO;
  localparam int HW = HMAX > 1 ? $clog2(HMAX) : 1;
  localparam logic [pWIDTH:0]   MAX_X  = (pWIDTH + 1)'(pMAX);
  localparam logic [pWIDTH:0]   STEP_X = (pWIDTH + 1)'(pSTEP);
  localparam logic [pWIDTH-1:0] MAX_D  = pWIDTH'(pMAX);
  localparam logic [pWIDTH-1:0] STEP_D = pWIDTH'(pSTEP);
  localparam logic [HW-1:0]     HI_L   = HW'(pHOLD_HI - 1);
  localparam logic [HW-1:0]     LO_L   = HW'(pHOLD_LO - 1);
  phase_e            state_q;
  logic [pWIDTH-1:0] duty_q;
  logic [HW-1:0]     hold_q;
  logic              done_q, stop_q, step, fin, div_clr;
  logic [pWIDTH:0]   sum;
  assign sum = {1'b0, duty_q} + STEP_X;
  assign div_clr = !bus.en || state_q == IDLE;
  // end of breath: last fall step with no low hold, or last low-hold step
  assign fin = step && ((state_q == FALL && duty_q <= STEP_D && pHOLD_LO == 0) ||
                        (state_q == HOLD_LO && hold_q == LO_L));
  brl_tick_div #(.pDIV(pDIV)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .tick_in (bus.end_tick),
    .tick_out(step)
  );
  // stop_q keeps a finished oneshot parked in IDLE until en is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else if (!bus.en) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        state_q <= bus.oneshot ? IDLE : RISE;
        stop_q  <= bus.oneshot;
        duty_q  <= '0;
        hold_q  <= '0;
      end else if (state_q == IDLE) begin
        if (!stop_q) state_q <= RISE;
      end else if (step) begin
        case (state_q)
          RISE:
            if (sum >= MAX_X) begin
              duty_q  <= MAX_D;
              state_q <= pHOLD_HI == 0 ? FALL : HOLD_HI;
            end else duty_q <= sum[pWIDTH-1:0];
          HOLD_HI:
            if (hold_q == HI_L) begin
              hold_q  <= '0;
              state_q <= FALL;
            end else hold_q <= hold_q + 1'b1;
          FALL:
            if (duty_q <= STEP_D) begin
              duty_q  <= '0;
              state_q <= HOLD_LO;
            end else duty_q <= duty_q - STEP_D;
          HOLD_LO: hold_q <= hold_q + 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  assign bus.cyc_duty = duty_q;
  assign bus.phase    = state_q;
  assign bus.cyc_done = done_q;
endmodule

// File: tb/tb_brl_sequencer.sv
// tb_brl_sequencer: three parameterisations checked every cycle against a breath-table model
module tb_brl_sequencer;
  logic clk, rst_n, en, oneshot, end_tick;
  int total, bad, cyc, gap;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    end_tick = 0;
    gap = 10;
    forever begin
      repeat (gap - 1) @(posedge clk);
      #2 end_tick = 1;
      @(posedge clk);
      #2 end_tick = 0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int ST = g == 1 ? 7 : 5;
    localparam int HH = g == 2 ? 0 : 3;
    localparam int HL = g == 2 ? 0 : 2;
    brl_sequencer_if #(.pWIDTH(10)) ifc ();
    assign ifc.en = en;
    assign ifc.oneshot = oneshot;
    assign ifc.end_tick = end_tick;
    brl_sequencer #(.pWIDTH(10), .pMAX(20), .pSTEP(ST), .pDIV(2), .pHOLD_HI(HH), .pHOLD_LO(HL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
    );
    // sd/sp: duty and phase shown after each step tick of one breath; phase -1 marks the breath end
    int sd[32], sp[32], n, m_duty, m_phase, m_done, k, c, dn, odd;
    bit m_stop;

    initial begin
      int d;
      d = 0;
      n = 0;
      while (d < 20) begin
        d = (d + ST >= 20) ? 20 : d + ST;
        sd[n] = d;
        sp[n] = d == 20 ? (HH > 0 ? 2 : 3) : 1;
        n++;
      end
      for (int i = 1; i <= HH; i++) begin
        sd[n] = 20;
        sp[n] = i == HH ? 3 : 2;
        n++;
      end
      while (d > 0) begin
        d = d <= ST ? 0 : d - ST;
        sd[n] = d;
        sp[n] = d > 0 ? 3 : (HL > 0 ? 4 : -1);
        n++;
      end
      for (int i = 1; i <= HL; i++) begin
        sd[n] = 0;
        sp[n] = i == HL ? -1 : 4;
        n++;
      end
    end

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_duty = 0; m_phase = 0; m_done = 0; k = 0; c = 0; m_stop = 0;
      end else begin
        m_done = 0;
        if (!en) begin
          m_duty = 0; m_phase = 0; c = 0; m_stop = 0;
        end else if (m_phase == 0) begin
          c = 0;
          if (!m_stop) begin
            m_phase = 1;
            k = 0;
          end
        end else if (end_tick) begin
          c++;
          if (c == 2) begin
            c = 0;
            m_duty = sd[k];
            if (sp[k] < 0) begin
              m_done = 1;
              m_stop = oneshot;
              m_phase = oneshot ? 0 : 1;
              k = 0;
            end else begin
              m_phase = sp[k];
              k++;
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      chk($sformatf("cfg%0d duty", g), int'(ifc.cyc_duty), m_duty);
      chk($sformatf("cfg%0d phase", g), int'(ifc.phase), m_phase);
      chk($sformatf("cfg%0d done", g), int'(ifc.cyc_done), m_done);
      if (ifc.cyc_done) dn++;
      if (ifc.phase == 3'd2 || ifc.phase == 3'd4) odd++;
    end
  end

  function automatic int duty_of(input int i);
    return i == 0 ? int'(cfg[0].ifc.cyc_duty) : i == 1 ? int'(cfg[1].ifc.cyc_duty) : int'(cfg[2].ifc.cyc_duty);
  endfunction

  function automatic int phase_of(input int i);
    return i == 0 ? int'(cfg[0].ifc.phase) : i == 1 ? int'(cfg[1].ifc.phase) : int'(cfg[2].ifc.phase);
  endfunction

  task automatic wait_duty(input int i, input int v, output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (duty_of(i) != v && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("reach cfg%0d duty %0d", i, v), duty_of(i), v);
    t = cyc;
  endtask

  initial begin
    int t, t5, t10, t20, t15, tf5, tf0, viol, s, rel, w;
    int sat[6];
    sat = '{7, 14, 20, 13, 6, 0};
    rst_n = 1;
    en = 0;
    oneshot = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset duty", duty_of(0), 0);
    chk("reset phase", phase_of(0), 0);
    chk("reset done", int'(cfg[0].ifc.cyc_done), 0);
    @(posedge clk);
    #2 rst_n = 1;
    en = 1;
    rel = cyc;

    wait_duty(0, 5, t5);
    wait_duty(0, 10, t10);
    chk("rise step spacing", t10 - t5, 20);
    wait_duty(0, 15, t);
    wait_duty(0, 20, t20);
    wait_duty(0, 15, t15);
    chk("peak span", t15 - t20, 80);
    wait_duty(0, 10, t);
    wait_duty(0, 5, tf5);
    wait_duty(0, 0, tf0);
    chk("fall step spacing", tf0 - tf5, 20);
    foreach (sat[i]) wait_duty(1, sat[i], t);
    while (cyc < rel + 600) @(posedge clk);
    chk("breaths cfg0", cfg[0].dn, 2);
    chk("breaths cfg1", cfg[1].dn, 2);
    chk("breaths cfg2", cfg[2].dn, 3);

    w = 0;
    while (!(duty_of(0) == 15 && phase_of(0) == 1) && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("drop point duty", duty_of(0), 15);
    s = cfg[0].dn;
    @(posedge clk);
    #2 en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("drop duty", duty_of(0), 0);
    chk("drop phase", phase_of(0), 0);
    repeat (50) @(posedge clk);
    #2 en = 1;
    chk("drop no done", cfg[0].dn - s, 0);
    wait_duty(0, 5, t5);
    wait_duty(0, 10, t10);
    chk("restart step spacing", t10 - t5, 20);

    @(posedge clk);
    #2 oneshot = 1;
    w = 0;
    while (cfg[0].ifc.cyc_done !== 1'b1 && w < 800) begin
      @(negedge clk);
      w++;
    end
    chk("oneshot done", int'(cfg[0].ifc.cyc_done), 1);
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (duty_of(0) != 0 || phase_of(0) != 0 || cfg[0].ifc.cyc_done) viol++;
    end
    chk("oneshot parked", viol, 0);
    @(posedge clk);
    #2 en = 0;
    oneshot = 0;
    @(posedge clk);
    #2 en = 1;

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(199) == 0) en = !en;
      if ($urandom_range(299) == 0) oneshot = !oneshot;
      if ($urandom_range(99) == 0) gap = $urandom_range(12, 2);
    end
    @(posedge clk);
    #2 en = 0;
    oneshot = 0;
    gap = 10;
    @(posedge clk);
    #2 en = 1;

    w = 0;
    while (phase_of(0) != 3 && w < 800) begin
      @(negedge clk);
      w++;
    end
    chk("fall reached", phase_of(0), 3);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async duty", duty_of(0), 0);
    chk("async phase", phase_of(0), 0);
    #14 rst_n = 1;
    wait_duty(0, 5, t5);
    wait_duty(0, 10, t10);
    chk("post reset spacing", t10 - t5, 20);
    chk("cfg2 hold phases", cfg[2].odd, 0);
    chk("cfg0 hold phases seen", int'(cfg[0].odd > 0), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
